// File: rtl/uart_loader_pkg.sv
// Shared types and frame constants for the UART program loader.
// Holds the receiver/loader state enums and the 8N1 framing parameters.
package uart_loader_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_FLUSH,
      LD_DONE
   } ld_state_t;

   // Byte-lane enables for a word holding n_bytes valid bytes; 0 means a full word.
   function automatic logic [3:0] lane_mask(input logic [1:0] n_bytes);
      case (n_bytes)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 UART receiver: synchronizes the line, validates the start bit
// at mid-bit, samples data LSB first and checks the stop bit(s).
module uart_rx_byte
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable,
   input  logic                 rx,
   output logic                 start_det,
   output logic                 busy,
   output logic                 byte_valid,
   output logic [DATA_BITS-1:0] byte_data,
   output logic                 frame_err
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);

   logic                 sync1_reg;
   logic                 sync2_reg;
   logic                 prev_reg;
   rx_state_t            state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [3:0]           bit_idx_reg;
   logic [DATA_BITS-1:0] shift_reg;

   assign busy      = (state_reg != RX_IDLE);
   assign byte_data = shift_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         prev_reg    <= 1'b1;
         state_reg   <= RX_IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         start_det   <= 1'b0;
         byte_valid  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sync1_reg  <= rx;
         sync2_reg  <= sync1_reg;
         prev_reg   <= sync2_reg;
         start_det  <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state_reg)
            RX_IDLE: begin
               if (enable && prev_reg && !sync2_reg) begin
                  state_reg <= RX_START;
                  cnt_reg   <= '0;
                  start_det <= 1'b1;
               end
            end
            RX_START: begin
               if (cnt_reg == CW'(HALF - 1)) begin
                  cnt_reg     <= '0;
                  bit_idx_reg <= '0;
                  state_reg   <= sync2_reg ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            RX_DATA: begin
               if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_reg   <= '0;
                  shift_reg <= {sync2_reg, shift_reg[DATA_BITS-1:1]};
                  if (bit_idx_reg == 4'(DATA_BITS - 1)) begin
                     bit_idx_reg <= '0;
                     state_reg   <= RX_STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_reg <= '0;
                  if (!sync2_reg) begin
                     frame_err <= 1'b1;
                     state_reg <= RX_WAIT_HIGH;
                  end else if (bit_idx_reg == 4'(STOP_BITS - 1)) begin
                     byte_valid <= 1'b1;
                     state_reg  <= RX_IDLE;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            RX_WAIT_HIGH: begin
               if (sync2_reg) state_reg <= RX_IDLE;
            end
            default: state_reg <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: packs received bytes into little-endian words, writes them
// through a one-entry request/grant port and releases the core after an idle timeout.
module uart_prog_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned IDLE_TIMEOUT = 4000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        uart_rx_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   output logic        boot_busy_o,
   output logic        done_o,
   output logic        frame_err_o,
   output logic        overrun_err_o,
   output logic [15:0] word_count_o
);

   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   logic        rx_enable;
   logic        rx_start;
   logic        rx_busy;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_frame_err;

   ld_state_t   ld_state_reg;
   logic [31:0] asm_reg;
   logic [1:0]  nbytes_reg;
   logic [TW-1:0] idle_cnt_reg;
   logic        pend_busy;

   assign rx_enable = (ld_state_reg == LD_IDLE) || (ld_state_reg == LD_LOAD);
   // The pending slot frees in the same cycle its grant is sampled.
   assign pend_busy = mem_req_o && !mem_gnt_i;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .enable    (rx_enable),
      .rx        (uart_rx_i),
      .start_det (rx_start),
      .busy      (rx_busy),
      .byte_valid(rx_valid),
      .byte_data (rx_data),
      .frame_err (rx_frame_err)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ld_state_reg  <= LD_IDLE;
         asm_reg       <= '0;
         nbytes_reg    <= '0;
         idle_cnt_reg  <= '0;
         mem_req_o     <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_addr_o    <= BASE_ADDR;
         mem_wdata_o   <= '0;
         mem_be_o      <= '0;
         done_o        <= 1'b0;
         boot_busy_o   <= 1'b1;
         frame_err_o   <= 1'b0;
         overrun_err_o <= 1'b0;
         word_count_o  <= '0;
      end else begin
         if (mem_req_o && mem_gnt_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= mem_addr_o + 32'd4;
            if (word_count_o != 16'hFFFF) word_count_o <= word_count_o + 16'd1;
         end
         if (rx_frame_err) frame_err_o <= 1'b1;

         case (ld_state_reg)
            LD_IDLE, LD_LOAD: begin
               if (rx_valid) begin
                  ld_state_reg <= LD_LOAD;
                  idle_cnt_reg <= '0;
                  if (nbytes_reg == 2'd3) begin
                     nbytes_reg <= '0;
                     asm_reg    <= '0;
                     if (pend_busy) begin
                        overrun_err_o <= 1'b1;
                     end else begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= {rx_data, asm_reg[23:0]};
                        mem_be_o    <= 4'hF;
                     end
                  end else begin
                     asm_reg[{nbytes_reg, 3'b000} +: 8] <= rx_data;
                     nbytes_reg <= nbytes_reg + 2'd1;
                  end
               end else if (ld_state_reg == LD_LOAD) begin
                  if (rx_start) begin
                     idle_cnt_reg <= '0;
                  end else if (idle_cnt_reg == TW'(IDLE_TIMEOUT)) begin
                     if (!rx_busy) ld_state_reg <= LD_FLUSH;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + TW'(1);
                  end
               end
            end
            LD_FLUSH: begin
               // Lanes beyond the received bytes are already zero in asm_reg.
               if (nbytes_reg != 2'd0) begin
                  if (!mem_req_o) begin
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= 1'b1;
                     mem_wdata_o <= asm_reg;
                     mem_be_o    <= lane_mask(nbytes_reg);
                     nbytes_reg  <= '0;
                     asm_reg     <= '0;
                  end
               end else if (!mem_req_o) begin
                  ld_state_reg <= LD_DONE;
                  done_o       <= 1'b1;
                  boot_busy_o  <= 1'b0;
               end
            end
            LD_DONE: begin
               done_o      <= 1'b1;
               boot_busy_o <= 1'b0;
            end
            default: ld_state_reg <= LD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: a byte-stream write model plus a per-cycle
// checker of the request/grant port, and literal checks at each scenario end.
module tb_uart_prog_loader;

   localparam int CLKS    = 48;
   localparam int TIMEOUT = 1000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        gnt = 1'b1;
   logic        mem_req_o, mem_we_o, boot_busy_o, done_o, frame_err_o, overrun_err_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [15:0] word_count_o;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state
   wr_t         exp_q[$];
   logic [31:0] m_acc;
   int          m_n;
   logic [31:0] m_addr;
   logic        m_ovr;
   logic [15:0] model_wc;

   // Observations of the checker
   logic        rst_prev = 1'b0;
   logic        prev_req = 1'b0, prev_gnt = 1'b0;
   logic [31:0] prev_addr, prev_data;
   logic [3:0]  prev_be;
   logic [31:0] last_addr, last_data;
   logic [3:0]  last_be;
   int          n_grants, stall_cycles;
   int          gmode = 0;   // 0: grant tied high, 1: 5-cycle stall, 2: grant held low
   int          stall_cnt = 0;

   uart_prog_loader #(
      .CLKS_PER_BIT(CLKS),
      .BASE_ADDR   (32'h0000_0000),
      .IDLE_TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .uart_rx_i    (rx),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (gnt),
      .boot_busy_o  (boot_busy_o),
      .done_o       (done_o),
      .frame_err_o  (frame_err_o),
      .overrun_err_o(overrun_err_o),
      .word_count_o (word_count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_acc = '0;
      m_n = 0;
      m_addr = 32'h0;
      m_ovr = 1'b0;
      n_grants = 0;
      stall_cycles = 0;
   endtask

   // A word that completes while an earlier one is still unwritten is lost.
   task automatic model_byte(input logic [7:0] b);
      m_acc[8*m_n +: 8] = b;
      m_n++;
      if (m_n == 4) begin
         if (exp_q.size() != 0) m_ovr = 1'b1;
         else begin
            exp_q.push_back('{m_addr, m_acc, 4'hF});
            m_addr = m_addr + 32'd4;
         end
         m_acc = '0;
         m_n = 0;
      end
   endtask

   task automatic model_flush();
      if (m_n > 0) begin
         exp_q.push_back('{m_addr, m_acc, 4'((1 << m_n) - 1)});
         m_addr = m_addr + 32'd4;
         m_acc = '0;
         m_n = 0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CLKS) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLKS) @(posedge clk);
      end
      rx = stop;
      repeat (CLKS) @(posedge clk);
      rx = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   // The model is told first, so expectations exist before the DUT can write.
   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      send_frame(b, 1'b1);
      $display("byte %h sent, model queue %0d", b, exp_q.size());
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rx = 1'b1;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      model_flush();
      k = 0;
      while (!done_o && k < 4 * TIMEOUT + 20 * CLKS) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      check(name, 32'(done_o), 32'd1);
   endtask

   // Grant driver
   always @(posedge clk) begin
      #1;
      if (gmode == 0) gnt = 1'b1;
      else if (gmode == 2) gnt = 1'b0;
      else if (mem_req_o) begin
         if (stall_cnt == 5) begin
            gnt = 1'b1;
            stall_cnt = 0;
         end else begin
            gnt = 1'b0;
            stall_cnt++;
         end
      end else begin
         gnt = 1'b0;
         stall_cnt = 0;
      end
   end

   // Per-cycle checker
   always @(negedge clk) begin
      if (rst) begin
         if (rst_prev) begin
            n_cmp++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, done_o, boot_busy_o,
                 frame_err_o, overrun_err_o, word_count_o} !==
                {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
               n_fail++;
               $display("FAIL reset_values: req %b we %b addr %h wdata %h be %h done %b busy %b fe %b oe %b wc %0d, want all reset values",
                        mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, done_o, boot_busy_o,
                        frame_err_o, overrun_err_o, word_count_o);
            end
         end
         model_wc = '0;
         prev_req = 1'b0;
         prev_gnt = 1'b0;
      end else begin
         check("word_count", 32'(word_count_o), 32'(model_wc));
         check("busy_vs_done", 32'(boot_busy_o), 32'(!done_o));
         if (mem_req_o) check("we_with_req", 32'(mem_we_o), 32'd1);
         if (prev_req && !prev_gnt) begin
            check("stall_req", 32'(mem_req_o), 32'd1);
            check("stall_addr", mem_addr_o, prev_addr);
            check("stall_data", mem_wdata_o, prev_data);
            check("stall_be", 32'(mem_be_o), 32'(prev_be));
         end
         if (prev_req && prev_gnt) check("req_drop", 32'(mem_req_o), 32'd0);
         if (mem_req_o && !gnt) stall_cycles++;
         if (mem_req_o && gnt) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_write: addr %h data %h be %h, want no write", mem_addr_o, mem_wdata_o, mem_be_o);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", mem_addr_o, e.addr);
               check("wr_data", mem_wdata_o, e.data);
               check("wr_be", 32'(mem_be_o), 32'(e.be));
            end
            $display("write addr %h data %h be %h", mem_addr_o, mem_wdata_o, mem_be_o);
            last_addr = mem_addr_o;
            last_data = mem_wdata_o;
            last_be = mem_be_o;
            n_grants++;
            if (model_wc != 16'hFFFF) model_wc = model_wc + 16'd1;
         end
         prev_req = mem_req_o;
         prev_gnt = gnt;
         prev_addr = mem_addr_o;
         prev_data = mem_wdata_o;
         prev_be = mem_be_o;
      end
      rst_prev = rst;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      model_wc = '0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("init_busy", 32'(boot_busy_o), 32'd1);
      check("init_done", 32'(done_o), 32'd0);

      // Single word, grant tied high
      gmode = 0;
      send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
      wait_done("t1_done");
      check("t1_busy", 32'(boot_busy_o), 32'd0);
      check("t1_wc", 32'(word_count_o), 32'd1);
      check("t1_addr", last_addr, 32'h0);
      check("t1_data", last_data, 32'h0020_0113);
      check("t1_be", 32'(last_be), 32'hF);
      check("t1_left", 32'(exp_q.size()), 32'd0);

      // Two words, grant stalled 5 cycles each
      do_reset();
      gmode = 1;
      send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      wait_done("t2_done");
      check("t2_wc", 32'(word_count_o), 32'd2);
      check("t2_addr", last_addr, 32'h4);
      check("t2_data", last_data, 32'h0000_0513);
      check("t2_stalls", 32'(stall_cycles), 32'd10);
      check("t2_left", 32'(exp_q.size()), 32'd0);

      // Glitch, long idle without a byte, then a bad stop bit
      do_reset();
      gmode = 0;
      rx = 1'b0;
      repeat (20) @(posedge clk);
      rx = 1'b1;
      repeat (TIMEOUT + 200) @(posedge clk);
      @(negedge clk);
      check("t3_no_done", 32'(done_o), 32'd0);
      check("t3_no_write", 32'(n_grants), 32'd0);
      check("t3_no_ferr", 32'(frame_err_o), 32'd0);
      send_frame(8'h55, 1'b0);
      repeat (TIMEOUT + 200) @(posedge clk);
      @(negedge clk);
      check("t3_ferr", 32'(frame_err_o), 32'd1);
      check("t3_no_write2", 32'(n_grants), 32'd0);
      check("t3_still_busy", 32'(boot_busy_o), 32'd1);

      // Partial word flush
      do_reset();
      gmode = 0;
      send_byte(8'hAA); send_byte(8'hBB);
      wait_done("t4_done");
      check("t4_data", last_data, 32'h0000_BBAA);
      check("t4_be", 32'(last_be), 32'h3);
      check("t4_wc", 32'(word_count_o), 32'd1);

      // Overrun while the grant is withheld
      do_reset();
      gmode = 2;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
      @(negedge clk);
      check("t5_ovr", 32'(overrun_err_o), 32'd1);
      check("t5_ovr_model", 32'(overrun_err_o), 32'(m_ovr));
      check("t5_req_held", 32'(mem_req_o), 32'd1);
      check("t5_data_held", mem_wdata_o, 32'h4433_2211);
      gmode = 0;
      wait_done("t5_done");
      check("t5_wc", 32'(word_count_o), 32'd1);

      // Reset during data bit 4, then a clean word
      do_reset();
      gmode = 0;
      rx = 1'b0;
      repeat (CLKS) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (CLKS) @(posedge clk);
      end
      repeat (CLKS / 2) @(posedge clk);
      do_reset();
      repeat (50) @(posedge clk);
      @(negedge clk);
      check("t6_ferr_clear", 32'(frame_err_o), 32'd0);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_done("t6_done");
      check("t6_data", last_data, 32'hEFBE_ADDE);
      check("t6_addr", last_addr, 32'h0);
      check("t6_wc", 32'(word_count_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, is the number of clk_i cycles per UART bit (10 MHz / 115200 baud).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first loaded word.
REQ-003 Parameter IDLE_TIMEOUT, default 4000, is the number of idle clk_i cycles that ends a load.
REQ-004 Port clk_i, input, 1 bit, is the single clock.
REQ-005 Port rst_i, input, 1 bit, is a synchronous, active-high reset.
REQ-006 Port uart_rx_i, input, 1 bit, is the asynchronous serial line: 8N1, LSB first, idle high.
REQ-007 Ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, 32), mem_wdata_o (output, 32) and mem_be_o (output, 4) form the memory write request.
REQ-008 Port mem_gnt_i, input, 1 bit, is the memory grant.
REQ-009 Port boot_busy_o, output, 1 bit, holds the core in reset while high.
REQ-010 Port done_o, output, 1 bit, indicates the load is complete.
REQ-011 Ports frame_err_o and overrun_err_o, outputs, 1 bit each, are sticky error flags.
REQ-012 Port word_count_o, output, 16 bits, counts the words written.

Function
REQ-013 uart_rx_i shall pass through a 2-flop synchronizer before any use.
REQ-014 A start bit shall be detected on a synchronized high-to-low transition while the receiver is idle.
REQ-015 Start validation: the line is re-sampled CLKS_PER_BIT/2 cycles after the edge; if high, the event is a glitch and the receiver returns to idle with no byte.
REQ-016 Data bits 0..7 shall be sampled every CLKS_PER_BIT cycles after start validation, LSB first; the stop bit is sampled CLKS_PER_BIT cycles after bit 7.
REQ-017 Stop bit = 1: the receiver emits a one-cycle byte-valid pulse with the data.
REQ-018 Stop bit = 0: the byte is dropped, frame_err_o is set, and the receiver waits for the line to return high before going idle.
REQ-019 The receiver FSM shall use the states RX_IDLE, RX_START, RX_DATA, RX_STOP and RX_WAIT_HIGH.
REQ-020 Word assembly is little-endian: the first received byte goes to wdata[7:0] and the fourth to wdata[31:24].
REQ-021 On the 4th byte, the word moves to a one-entry pending-write register in the following cycle.
REQ-022 Write handshake: mem_req_o=1 and mem_we_o=1; addr, wdata and be stay stable until mem_gnt_i is sampled 1; mem_req_o drops in the cycle after the grant.
REQ-023 The write address starts at BASE_ADDR and increments by 4 per granted write, wrapping modulo 2^32.
REQ-024 word_count_o increments on each grant and saturates at 16'hFFFF.
REQ-025 A full word that completes while the pending register is still occupied is dropped and sets overrun_err_o; the address does not advance.
REQ-026 The loader FSM shall use the states LD_IDLE, LD_LOAD, LD_FLUSH and LD_DONE.
REQ-027 LD_IDLE to LD_LOAD occurs on the first valid byte.
REQ-028 No timeout runs in LD_IDLE.
REQ-029 In LD_LOAD, the idle counter clears on any start-bit detection and otherwise counts.
REQ-030 Reaching IDLE_TIMEOUT (with no receive in progress) moves the loader to LD_FLUSH.
REQ-031 In LD_FLUSH, a partial word (1-3 bytes) is written zero-filled, with mem_be_o set only for the valid bytes (e.g. 2 bytes gives 4'b0011).
REQ-032 LD_FLUSH moves to LD_DONE once all pending writes are granted.
REQ-033 In LD_DONE: done_o=1, boot_busy_o=0, and all UART input is ignored until reset.
REQ-034 If a timeout and a byte-valid pulse occur in the same cycle, the byte takes priority and the counter clears.

Reset
REQ-035 Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, mem_be_o=0, done_o=0, boot_busy_o=1, frame_err_o=0, overrun_err_o=0, word_count_o=0.
REQ-036 Both FSMs return to their IDLE states on reset.
REQ-037 Reset mid-frame or mid-handshake discards all partial state; the next falling edge after reset starts a fresh frame.

Structure
REQ-038 The receiver and loader state enums and the 8N1 frame constants (8 data bits, 1 stop bit) shall live in the shared package uart_loader_pkg.
REQ-039 The bit-level receiver (REQ-013 to REQ-019) shall be the sub-module uart_rx_byte; uart_prog_loader instantiates it and implements word assembly, the write handshake and timeout.

Verification
REQ-040 Bytes 13,01,20,00 with mem_gnt_i tied high -> one write, addr 0x0, wdata 0x00200113, be 4'hF; after the timeout, done_o=1, boot_busy_o=0 and word_count_o=1.
REQ-041 Eight bytes for 0x00200113 then 0x00000513, with the grant held low for 5 cycles per request -> request signals stable for the 5 stall cycles; writes to 0x0 then 0x4; word_count_o=2.
REQ-042 A 20-cycle low pulse on an idle line -> no byte, no write, state stays LD_IDLE; a frame with stop bit 0 -> frame_err_o=1 and no write.
REQ-043 Bytes AA,BB then idle for IDLE_TIMEOUT -> write wdata 0x0000BBAA, be 4'b0011, then done_o=1.
REQ-044 Grant held low for 4000 cycles while 8 further bytes arrive -> overrun_err_o=1 and the second word is dropped.
REQ-045 rst_i asserted during data bit 4 -> all outputs at reset values; a following clean frame is received correctly.
